// File: rtl/branch_unit_ooo.sv
// Out-of-order branch execution unit: a reservation station with CDB operand
// snooping and oldest-ready-first selection, feeding one execute register that
// resolves the branch for the front end and writes the link value on the CDB.

package expipe_pkg;
    localparam int XLEN        = 32;
    localparam int ROB_IDX_LEN = 4;
    localparam int BU_CTL_LEN  = 3;

    typedef enum logic [BU_CTL_LEN-1:0] {
        BU_BEQ  = 3'd0,
        BU_BNE  = 3'd1,
        BU_BLT  = 3'd2,
        BU_BGE  = 3'd3,
        BU_BLTU = 3'd4,
        BU_BGEU = 3'd5,
        BU_JAL  = 3'd6,
        BU_JALR = 3'd7
    } bu_ctl_t;

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0] rob_idx;
        logic [XLEN-1:0]        value;
        logic                   except_raised;
        logic [3:0]             except_code;
    } cdb_data_t;
endpackage

module branch_unit_ooo
    import expipe_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter bit LINK_WB = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic [BU_CTL_LEN-1:0]  branch_type_i,
    input  logic                   rs1_ready_i,
    input  logic                   rs2_ready_i,
    input  logic [ROB_IDX_LEN-1:0] rs1_idx_i,
    input  logic [ROB_IDX_LEN-1:0] rs2_idx_i,
    input  logic [XLEN-1:0]        rs1_value_i,
    input  logic [XLEN-1:0]        rs2_value_i,
    input  logic [XLEN-1:0]        imm_value_i,
    input  logic [ROB_IDX_LEN-1:0] dest_idx_i,
    input  logic [XLEN-1:0]        pred_pc_i,
    input  logic [XLEN-1:0]        pred_target_i,
    input  logic                   pred_taken_i,
    output logic                   res_valid_o,
    output logic [XLEN-1:0]        res_pc_o,
    output logic [XLEN-1:0]        res_target_o,
    output logic                   res_taken_o,
    output logic                   res_mispredict_o,
    input  logic                   cdb_valid_i,
    input  cdb_data_t              cdb_data_i,
    input  logic                   cdb_ready_i,
    output logic                   cdb_valid_o,
    output cdb_data_t              cdb_data_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        bu_ctl_t                btype;
        logic                   rs1_rdy;
        logic [ROB_IDX_LEN-1:0] rs1_idx;
        logic [XLEN-1:0]        rs1_val;
        logic                   rs2_rdy;
        logic [ROB_IDX_LEN-1:0] rs2_idx;
        logic [XLEN-1:0]        rs2_val;
        logic [XLEN-1:0]        imm;
        logic [ROB_IDX_LEN-1:0] dest;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        pred_target;
        logic                   pred_taken;
    } rs_entry_t;

    typedef struct packed {
        bu_ctl_t                btype;
        logic [XLEN-1:0]        rs1;
        logic [XLEN-1:0]        rs2;
        logic [XLEN-1:0]        imm;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        pred_target;
        logic                   pred_taken;
        logic [ROB_IDX_LEN-1:0] dest;
    } ex_t;

    // Reservation station state. older_q[i][j] means entry i was issued before entry j.
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
    rs_entry_t                   entry_q [DEPTH];
    rs_entry_t                   entry_d [DEPTH];

    // Execute register.
    logic ex_valid_q, ex_valid_d;
    ex_t  ex_q, ex_d;
    logic sent_q, sent_d;

    logic             alloc_found;
    logic [IDX_W-1:0] alloc_idx;
    logic             do_alloc;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic             ex_retire;
    logic             ex_load;
    rs_entry_t        new_entry;
    logic             rs1_bypass, rs2_bypass;

    logic            taken;
    logic            is_link;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_pc;
    logic            mispredict;

    // Exception fields of the snooped CDB are irrelevant to operand capture.
    logic unused_cdb_exc;
    assign unused_cdb_exc = cdb_data_i.except_raised ^ (^cdb_data_i.except_code);

    // Ready only reflects registered occupancy; a slot freed this cycle is not reusable yet.
    assign issue_ready_o = |(~valid_q);
    assign do_alloc      = issue_valid_i & issue_ready_o & ~flush_i;

    assign ex_retire = ex_valid_q & cdb_ready_i;
    assign ex_load   = sel_valid & (~ex_valid_q | ex_retire) & ~flush_i;

    // Lowest-index free entry.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    // Oldest ready entry: a candidate no other candidate is older than.
    always_comb begin
        cand    = '0;
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = valid_q[i] & entry_q[i].rs1_rdy & entry_q[i].rs2_rdy;
        end
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh[i] = cand[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && cand[j] && older_q[j][i]) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        sel_valid = |cand;
    end

    // Incoming entry, with same-cycle CDB bypass for operands not yet ready.
    always_comb begin
        rs1_bypass            = ~rs1_ready_i & cdb_valid_i & (cdb_data_i.rob_idx == rs1_idx_i);
        rs2_bypass            = ~rs2_ready_i & cdb_valid_i & (cdb_data_i.rob_idx == rs2_idx_i);
        new_entry.btype       = bu_ctl_t'(branch_type_i);
        new_entry.rs1_rdy     = rs1_ready_i | rs1_bypass;
        new_entry.rs1_idx     = rs1_idx_i;
        new_entry.rs1_val     = rs1_bypass ? cdb_data_i.value : rs1_value_i;
        new_entry.rs2_rdy     = rs2_ready_i | rs2_bypass;
        new_entry.rs2_idx     = rs2_idx_i;
        new_entry.rs2_val     = rs2_bypass ? cdb_data_i.value : rs2_value_i;
        new_entry.imm         = imm_value_i;
        new_entry.dest        = dest_idx_i;
        new_entry.pc          = pred_pc_i;
        new_entry.pred_target = pred_target_i;
        new_entry.pred_taken  = pred_taken_i;
    end

    // RS next state: snoop, free the selected entry, allocate the new one as youngest.
    always_comb begin
        valid_d = valid_q;
        older_d = older_q;
        entry_d = entry_q;
        if (flush_i) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && cdb_valid_i) begin
                    if (!entry_q[i].rs1_rdy && entry_q[i].rs1_idx == cdb_data_i.rob_idx) begin
                        entry_d[i].rs1_rdy = 1'b1;
                        entry_d[i].rs1_val = cdb_data_i.value;
                    end
                    if (!entry_q[i].rs2_rdy && entry_q[i].rs2_idx == cdb_data_i.rob_idx) begin
                        entry_d[i].rs2_rdy = 1'b1;
                        entry_d[i].rs2_val = cdb_data_i.value;
                    end
                end
            end
            if (ex_load) begin
                valid_d[sel_idx] = 1'b0;
            end
            if (do_alloc && alloc_found) begin
                valid_d[alloc_idx] = 1'b1;
                entry_d[alloc_idx] = new_entry;
                older_d[alloc_idx] = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    older_d[j][alloc_idx] = valid_q[j];
                end
            end
        end
    end

    // EX next state: load on a free or retiring slot, hold during a CDB stall.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (ex_load) begin
            ex_valid_d       = 1'b1;
            ex_d.btype       = entry_q[sel_idx].btype;
            ex_d.rs1         = entry_q[sel_idx].rs1_val;
            ex_d.rs2         = entry_q[sel_idx].rs2_val;
            ex_d.imm         = entry_q[sel_idx].imm;
            ex_d.pc          = entry_q[sel_idx].pc;
            ex_d.pred_target = entry_q[sel_idx].pred_target;
            ex_d.pred_taken  = entry_q[sel_idx].pred_taken;
            ex_d.dest        = entry_q[sel_idx].dest;
        end else if (ex_retire) begin
            ex_valid_d = 1'b0;
        end
        // The resolution has been reported once EX survives a cycle without retiring.
        sent_d = ex_valid_q & ~ex_retire & ~flush_i;
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rst_n_i) begin
            valid_q    <= '0;
            older_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            sent_q     <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            older_q    <= older_d;
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            sent_q     <= sent_d;
        end
    end

    // RS payload storage.
    // NOTE: payload is not reset; it is only ever read behind a valid bit, so
    // resetting it would add reset fan-out for no behavioural gain.
    always_ff @(posedge clk_i) begin
        entry_q <= entry_d;
    end

    // Branch resolution from the EX register.
    always_comb begin
        link_pc = ex_q.pc + XLEN'(4);
        is_link = (ex_q.btype == BU_JAL) || (ex_q.btype == BU_JALR);
        case (ex_q.btype)
            BU_BEQ:  taken = (ex_q.rs1 == ex_q.rs2);
            BU_BNE:  taken = (ex_q.rs1 != ex_q.rs2);
            BU_BLT:  taken = ($signed(ex_q.rs1) <  $signed(ex_q.rs2));
            BU_BGE:  taken = ($signed(ex_q.rs1) >= $signed(ex_q.rs2));
            BU_BLTU: taken = (ex_q.rs1 <  ex_q.rs2);
            BU_BGEU: taken = (ex_q.rs1 >= ex_q.rs2);
            default: taken = 1'b1;
        endcase
        if (ex_q.btype == BU_JALR) begin
            target = (ex_q.rs1 + ex_q.imm) & {{(XLEN-1){1'b1}}, 1'b0};
        end else begin
            target = ex_q.pc + ex_q.imm;
        end
        mispredict = (taken != ex_q.pred_taken) | (taken & (target != ex_q.pred_target));
    end

    // Outputs are zero whenever EX is empty.
    always_comb begin
        res_valid_o      = ex_valid_q & ~sent_q;
        res_pc_o         = ex_valid_q ? ex_q.pc : '0;
        res_target_o     = ex_valid_q ? (taken ? target : link_pc) : '0;
        res_taken_o      = ex_valid_q & taken;
        res_mispredict_o = ex_valid_q & mispredict;
        cdb_valid_o      = ex_valid_q;
        cdb_data_o       = '0;
        if (ex_valid_q) begin
            cdb_data_o.rob_idx = ex_q.dest;
            cdb_data_o.value   = (LINK_WB && is_link) ? link_pc : '0;
        end
    end

endmodule

// File: tb/tb_branch_unit_ooo.sv
// Scoreboard bench for branch_unit_ooo: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever res_valid_o is seen.

module tb_branch_unit_ooo;
    import expipe_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i;
    logic                   flush_i;
    logic                   issue_valid_i;
    logic                   issue_ready_o;
    logic [BU_CTL_LEN-1:0]  branch_type_i;
    logic                   rs1_ready_i, rs2_ready_i;
    logic [ROB_IDX_LEN-1:0] rs1_idx_i, rs2_idx_i;
    logic [XLEN-1:0]        rs1_value_i, rs2_value_i, imm_value_i;
    logic [ROB_IDX_LEN-1:0] dest_idx_i;
    logic [XLEN-1:0]        pred_pc_i, pred_target_i;
    logic                   pred_taken_i;
    logic                   res_valid_o;
    logic [XLEN-1:0]        res_pc_o, res_target_o;
    logic                   res_taken_o, res_mispredict_o;
    logic                   cdb_valid_i;
    cdb_data_t              cdb_data_i;
    logic                   cdb_ready_i;
    logic                   cdb_valid_o;
    cdb_data_t              cdb_data_o;

    branch_unit_ooo #(.DEPTH(3), .LINK_WB(1'b1)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .branch_type_i(branch_type_i),
        .rs1_ready_i(rs1_ready_i), .rs2_ready_i(rs2_ready_i),
        .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i),
        .rs1_value_i(rs1_value_i), .rs2_value_i(rs2_value_i),
        .imm_value_i(imm_value_i), .dest_idx_i(dest_idx_i),
        .pred_pc_i(pred_pc_i), .pred_target_i(pred_target_i), .pred_taken_i(pred_taken_i),
        .res_valid_o(res_valid_o), .res_pc_o(res_pc_o), .res_target_o(res_target_o),
        .res_taken_o(res_taken_o), .res_mispredict_o(res_mispredict_o),
        .cdb_valid_i(cdb_valid_i), .cdb_data_i(cdb_data_i), .cdb_ready_i(cdb_ready_i),
        .cdb_valid_o(cdb_valid_o), .cdb_data_o(cdb_data_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        misp;
        logic [3:0]  rob;
        logic [31:0] value;
        int          at_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic mp, input logic [3:0] rob, input logic [31:0] val,
                        input int at);
        exp_t e;
        e.pc = pc; e.target = tgt; e.taken = tk; e.misp = mp;
        e.rob = rob; e.value = val; e.at_cyc = at;
        sb_q.push_back(e);
    endtask

    // Drives one issue for a single cycle; returns one cycle later.
    task automatic issue(input bu_ctl_t t, input logic [31:0] pc, input logic [31:0] imm,
                         input logic r1rdy, input logic [3:0] r1idx, input logic [31:0] r1val,
                         input logic r2rdy, input logic [3:0] r2idx, input logic [31:0] r2val,
                         input logic [3:0] dest, input logic ptk, input logic [31:0] ptgt);
        issue_valid_i = 1'b1;
        branch_type_i = t;
        pred_pc_i     = pc;
        imm_value_i   = imm;
        rs1_ready_i   = r1rdy; rs1_idx_i = r1idx; rs1_value_i = r1val;
        rs2_ready_i   = r2rdy; rs2_idx_i = r2idx; rs2_value_i = r2val;
        dest_idx_i    = dest;
        pred_taken_i  = ptk;
        pred_target_i = ptgt;
        tick();
        issue_valid_i = 1'b0;
    endtask

    task automatic bcast(input logic [3:0] idx, input logic [31:0] val);
        cdb_valid_i        = 1'b1;
        cdb_data_i         = '0;
        cdb_data_i.rob_idx = idx;
        cdb_data_i.value   = val;
    endtask

    task automatic bcast_off();
        cdb_valid_i = 1'b0;
        cdb_data_i  = '0;
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_n_i && res_valid_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result_pc", res_pc_o, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("res_cycle",      cyc,               e.at_cyc);
                check("res_pc",         res_pc_o,          e.pc);
                check("res_target",     res_target_o,      e.target);
                check("res_taken",      {31'd0, res_taken_o},      {31'd0, e.taken});
                check("res_mispredict", {31'd0, res_mispredict_o}, {31'd0, e.misp});
                check("cdb_valid",      {31'd0, cdb_valid_o},      32'd1);
                check("cdb_rob_idx",    {28'd0, cdb_data_o.rob_idx}, {28'd0, e.rob});
                check("cdb_value",      cdb_data_o.value,  e.value);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n_i = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0;
        branch_type_i = '0; rs1_ready_i = 1'b0; rs2_ready_i = 1'b0;
        rs1_idx_i = '0; rs2_idx_i = '0; rs1_value_i = '0; rs2_value_i = '0;
        imm_value_i = '0; dest_idx_i = '0; pred_pc_i = '0; pred_target_i = '0;
        pred_taken_i = 1'b0; cdb_valid_i = 1'b0; cdb_data_i = '0; cdb_ready_i = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_issue_ready", {31'd0, issue_ready_o}, 32'd1);
        check("rst_res_valid",   {31'd0, res_valid_o},   32'd0);
        check("rst_cdb_valid",   {31'd0, cdb_valid_o},   32'd0);
        check("rst_res_pc",      res_pc_o,               32'd0);
        check("rst_res_target",  res_target_o,           32'd0);
        check("rst_cdb_value",   cdb_data_o.value,       32'd0);
        rst_n_i = 1'b1;
        repeat (2) tick();

        // 1: BEQ taken, predicted not-taken
        c0 = cyc;
        issue(BU_BEQ, 32'h100, 32'd16, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5, 4'd1, 1'b0, 32'h0);
        push(32'h100, 32'h110, 1'b1, 1'b1, 4'd1, 32'h0, c0 + 2);
        repeat (4) tick();

        // 2: JALR with bit-0 clear, correctly predicted, link on CDB
        c0 = cyc;
        issue(BU_JALR, 32'h40, 32'd4, 1'b1, 4'd0, 32'h203, 1'b1, 4'd0, 32'h0, 4'd2, 1'b1, 32'h206);
        push(32'h40, 32'h206, 1'b1, 1'b0, 4'd2, 32'h44, c0 + 2);
        repeat (4) tick();

        // 3a: A waits on ROB 7, B ready and younger resolves first
        c0 = cyc;
        issue(BU_BNE, 32'h200, 32'd8, 1'b0, 4'd7, 32'd3, 1'b1, 4'd0, 32'd3, 4'd3, 1'b1, 32'h208);
        issue(BU_BLT, 32'h300, 32'hFFFF_FFFC, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b1, 4'd0, 32'd1,
              4'd4, 1'b1, 32'h2FC);
        push(32'h300, 32'h2FC, 1'b1, 1'b0, 4'd4, 32'h0, c0 + 3);
        push(32'h200, 32'h208, 1'b1, 1'b0, 4'd3, 32'h0, c0 + 4);
        bcast(4'd7, 32'd9);
        tick();
        bcast_off();
        repeat (4) tick();

        // 3b: broadcast in A's issue cycle -> bypass, A resolves before B
        c0 = cyc;
        bcast(4'd7, 32'd9);
        issue(BU_BGEU, 32'h400, 32'h20, 1'b0, 4'd7, 32'hFFFF_FFFF, 1'b1, 4'd0, 32'hFFFF_FFFF,
              4'd5, 1'b1, 32'h420);
        bcast_off();
        push(32'h400, 32'h404, 1'b0, 1'b1, 4'd5, 32'h0, c0 + 2);
        issue(BU_BGE, 32'h500, 32'h10, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b1, 4'd0, 32'h0,
              4'd6, 1'b0, 32'h0);
        push(32'h500, 32'h504, 1'b0, 1'b0, 4'd6, 32'h0, c0 + 3);
        repeat (4) tick();

        // 3c: both operands captured from one broadcast
        c0 = cyc;
        issue(BU_BEQ, 32'h900, 32'hC, 1'b0, 4'd11, 32'd1, 1'b0, 4'd11, 32'd2, 4'd7, 1'b0, 32'h0);
        push(32'h900, 32'h90C, 1'b1, 1'b1, 4'd7, 32'h0, c0 + 3);
        bcast(4'd11, 32'h55);
        tick();
        bcast_off();
        repeat (4) tick();

        // 4: fill all 3 entries, ready drops; freeing one raises it a cycle late
        c0 = cyc;
        issue(BU_BEQ,  32'h580, 32'h80,  1'b0, 4'd8,  32'd0, 1'b1, 4'd0, 32'd4, 4'd1, 1'b1, 32'h600);
        issue(BU_BLTU, 32'h600, 32'h40,  1'b0, 4'd9,  32'd7, 1'b1, 4'd0, 32'd3, 4'd2, 1'b0, 32'h0);
        issue(BU_JAL,  32'h700, 32'h100, 1'b0, 4'd10, 32'd0, 1'b1, 4'd0, 32'd0, 4'd3, 1'b1, 32'h7F0);
        check("full_issue_ready", {31'd0, issue_ready_o}, 32'd0);
        push(32'h600, 32'h640, 1'b1, 1'b1, 4'd2, 32'h0,   c0 + 5);
        push(32'h580, 32'h600, 1'b1, 1'b0, 4'd1, 32'h0,   c0 + 7);
        push(32'h700, 32'h800, 1'b1, 1'b1, 4'd3, 32'h704, c0 + 8);
        bcast(4'd9, 32'd2);
        tick();
        bcast_off();
        check("select_cycle_issue_ready", {31'd0, issue_ready_o}, 32'd0);
        tick();
        check("freed_issue_ready", {31'd0, issue_ready_o}, 32'd1);
        bcast(4'd8, 32'd4);
        tick();
        bcast(4'd10, 32'h1234);
        tick();
        bcast_off();
        repeat (4) tick();

        // 5: CDB stall for 3 cycles holds EX and suppresses repeat pulses
        c0 = cyc;
        cdb_ready_i = 1'b0;
        issue(BU_BGE, 32'hA00, 32'h8,  1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5, 4'd10, 1'b1, 32'hA08);
        push(32'hA00, 32'hA08, 1'b1, 1'b0, 4'd10, 32'h0, c0 + 2);
        issue(BU_JAL, 32'hB00, 32'h20, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0, 4'd11, 1'b1, 32'hB20);
        push(32'hB00, 32'hB20, 1'b1, 1'b0, 4'd11, 32'hB04, c0 + 6);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_res_valid", {31'd0, res_valid_o}, 32'd0);
            check("stall_cdb_valid", {31'd0, cdb_valid_o}, 32'd1);
            check("stall_cdb_rob",   {28'd0, cdb_data_o.rob_idx}, 32'd10);
            check("stall_cdb_value", cdb_data_o.value, 32'd0);
            check("stall_res_pc",    res_pc_o, 32'hA00);
        end
        cdb_ready_i = 1'b1;
        tick();
        check("after_stall_cdb_rob", {28'd0, cdb_data_o.rob_idx}, 32'd11);
        repeat (4) tick();

        // 6: flush with EX full, two RS entries and a simultaneous issue
        c0 = cyc;
        cdb_ready_i = 1'b0;
        issue(BU_BEQ, 32'hC00, 32'h10, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2, 4'd12, 1'b0, 32'h0);
        push(32'hC00, 32'hC04, 1'b0, 1'b0, 4'd12, 32'h0, c0 + 2);
        issue(BU_BNE, 32'hC40, 32'h4, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'd0, 4'd13, 1'b0, 32'h0);
        issue(BU_BNE, 32'hC80, 32'h4, 1'b0, 4'd13, 32'd0, 1'b1, 4'd0, 32'd0, 4'd14, 1'b0, 32'h0);
        flush_i = 1'b1;
        bcast(4'd12, 32'd1);
        issue(BU_JAL, 32'hE00, 32'h8, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0, 4'd15, 1'b1, 32'hE08);
        flush_i = 1'b0;
        bcast_off();
        check("flush_issue_ready", {31'd0, issue_ready_o}, 32'd1);
        check("flush_cdb_valid",   {31'd0, cdb_valid_o},   32'd0);
        check("flush_res_valid",   {31'd0, res_valid_o},   32'd0);
        cdb_ready_i = 1'b1;
        bcast(4'd13, 32'd1);
        tick();
        bcast_off();
        repeat (5) tick();
        c0 = cyc;
        issue(BU_BNE, 32'hD00, 32'h40, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2, 4'd14, 1'b1, 32'hD40);
        push(32'hD00, 32'hD40, 1'b1, 1'b0, 4'd14, 32'h0, c0 + 2);
        repeat (4) tick();

        // Asynchronous reset mid-operation with a full RS
        issue(BU_BEQ, 32'h10, 32'h4, 1'b0, 4'd15, 32'd0, 1'b1, 4'd0, 32'd0, 4'd1, 1'b0, 32'h0);
        issue(BU_BEQ, 32'h14, 32'h4, 1'b0, 4'd15, 32'd0, 1'b1, 4'd0, 32'd0, 4'd2, 1'b0, 32'h0);
        issue(BU_BEQ, 32'h18, 32'h4, 1'b0, 4'd15, 32'd0, 1'b1, 4'd0, 32'd0, 4'd3, 1'b0, 32'h0);
        check("prereset_issue_ready", {31'd0, issue_ready_o}, 32'd0);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_rst_issue_ready", {31'd0, issue_ready_o}, 32'd1);
        check("async_rst_cdb_valid",   {31'd0, cdb_valid_o},   32'd0);
        tick();
        rst_n_i = 1'b1;
        repeat (3) tick();

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_unit_ooo.md
Name: branch_unit_ooo

Overview:
Second-generation branch execution unit with a reservation station of any depth, in-program-order arrival, and oldest-ready-first selection. Each entry snoops the CDB for its operands. A single execute register resolves the branch (condition, target, mispredict) and reports the result to the front end. It also writes the link value (pc+4) for JAL/JALR on the CDB. Sits between the issue logic and the CDB/front end, in place of the first-generation branch unit.

Parameters:
DEPTH, 4, number of RS entries; any value >= 2, not restricted to a power of 2.
LINK_WB, 1, 1: JAL/JALR write pc+4 to CDB; 0: all branches write value 0 (CDB used only to mark ROB completion).

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous pipeline flush
issue_valid_i  in  1  issue request
issue_ready_o  out  1  RS can accept
branch_type_i  in  BU_CTL_LEN  BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR (expipe_pkg encoding)
rs1_ready_i, rs2_ready_i  in  1  operand value valid
rs1_idx_i, rs2_idx_i  in  ROB_IDX_LEN  producer ROB index
rs1_value_i, rs2_value_i  in  XLEN  operand values
imm_value_i  in  XLEN  sign-extended offset
dest_idx_i  in  ROB_IDX_LEN  ROB entry of the branch
pred_pc_i, pred_target_i  in  XLEN  instruction PC, predicted target
pred_taken_i  in  1  predicted direction
res_valid_o  out  1  resolution valid (one-cycle pulse)
res_pc_o, res_target_o  out  XLEN  branch PC, resolved next PC
res_taken_o, res_mispredict_o  out  1  resolved direction, mispredict
cdb_valid_i  in  1  CDB carries valid data (snoop)
cdb_data_i  in  cdb_data_t  CDB snoop data (rob_idx, value)
cdb_ready_i  in  1  CDB grant
cdb_valid_o  out  1  writeback request
cdb_data_o  out  cdb_data_t  rob_idx=dest, value=link, exception fields 0

Behaviour:
- Reset: all entries invalid, EX register empty. issue_ready_o=1; res_valid_o=0, cdb_valid_o=0, all data outputs 0.
- Allocation: issue_ready_o = (occupancy < DEPTH), from registered state only. A free slot in the same cycle does not raise ready. On issue_valid_i & issue_ready_o, write the lowest-index free entry and mark it youngest.
- Allocation bypass: if rsX_ready_i=0 and cdb_valid_i and cdb_data_i.rob_idx==rsX_idx_i in the same cycle, store the value as ready.
- Snoop: every valid entry with a not-ready operand whose idx matches a valid CDB captures cdb_data_i.value and sets ready next edge. Both operands may capture from one broadcast.
- Selection: candidates are valid entries with both operands ready. Pick the oldest by issue order; equal age cannot occur. The pick moves to the EX register when EX is empty or EX is retiring this cycle. The entry is freed on that same edge.
- Latency: issue with both operands ready in cycle 0 gives res_valid_o and cdb_valid_o in cycle 2. Back-to-back ready branches give one result per cycle when cdb_ready_i=1.
- EX resolution (combinational from EX register):
  - taken: per type, with signed compares for BLT/BGE and unsigned for BLTU/BGEU. JAL/JALR are always taken.
  - target: JALR gives (rs1+imm)&~1; all other types give pc+imm. Arithmetic is modulo 2^XLEN.
  - res_target_o = taken ? target : pc+4.
  - res_mispredict_o = (taken != pred_taken) | (taken & target != pred_target).
- EX retire: cdb_valid_o is high while EX is full. EX retires on cdb_valid_o & cdb_ready_i. While stalled, EX holds its contents and cdb_data_o is stable.
- res_valid_o: asserted only in the first cycle EX holds a given branch. A sent flag suppresses repeats during a CDB stall.
- Flush: next edge invalidates all entries and EX, and clears the sent flag. issue_valid_i in the flush cycle is ignored, as are CDB snoop updates. Outputs are 0 the following cycle.
- Reset mid-operation: asynchronous, returns to the reset state immediately.

Test Plan:
1. Reset, then issue BEQ with rs1=rs2=5, imm=16, pc=0x100, pred_taken=0 -> cycle 2: res_valid_o=1, taken=1, res_target_o=0x110, mispredict=1; cdb rob_idx=dest, value=0.
2. Issue JALR with rs1=0x203, imm=4, pc=0x40, pred_target=0x206, LINK_WB=1 -> target 0x206, taken=1, mispredict=0, cdb value 0x44.
3. Issue A (rs1 waits on ROB 7), then B (ready), then CDB broadcasts rob 7=9 -> B resolves first. A resolves the cycle after its capture plus 1, using rs1=9. Same test with the broadcast in A's issue cycle: A captures via bypass and resolves before B.
4. Fill DEPTH=3 entries, all not ready -> issue_ready_o=0. Make one ready -> ready stays 0 in the selection cycle and rises the following cycle.
5. Hold cdb_ready_i=0 for 3 cycles with a result in EX -> res_valid_o pulses once, cdb_valid_o stays high with stable data, and no RS entry enters EX. Releasing retires the branch and the next branch follows.
6. flush_i with 2 entries plus EX full and a simultaneous issue -> next cycle issue_ready_o=1, cdb_valid_o=0, res_valid_o=0, and the issued op is absent.
